// File: rtl/lock_code_sender.sv
// Initiator for the 4-digit sequential combination lock: presents a latched code
// one digit per cycle, then reports pass/fail and measures the unlock window.
module lock_code_sender #(
  parameter logic [2:0]  IDLE_SW  = 3'b111,
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned LEN_W    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [11:0]      code,
  input  logic [1:0]       selsw,
  input  logic             locked,
  input  logic             alarm,
  input  logic             entimer,
  output logic             lock_clr,
  output logic [2:0]       sw_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [1:0]       fail_idx,
  output logic [LEN_W-1:0] unlock_len
);

  localparam int unsigned WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_WRONG   = 2'b01;
  localparam logic [1:0] FC_DESYNC  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_MEAS, S_FIN} state_t;

  state_t             state, state_n;
  logic [11:0]        code_q, code_n;
  logic [1:0]         idx, idx_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_n;
  logic               lock_clr_n, busy_n, done_n, pass_n;
  logic [2:0]         sw_out_n;
  logic [1:0]         fail_code_n, fail_idx_n;
  logic [LEN_W-1:0]   unlock_len_n;

  function automatic logic [2:0] digit(input logic [11:0] c, input logic [1:0] i);
    return c[int'(i)*3 +: 3];
  endfunction

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= S_IDLE;
      code_q     <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      lock_clr   <= 1'b1;
      sw_out     <= IDLE_SW;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_code  <= FC_NONE;
      fail_idx   <= 2'b00;
      unlock_len <= '0;
    end else begin
      state      <= state_n;
      code_q     <= code_n;
      idx        <= idx_n;
      wait_cnt   <= wait_cnt_n;
      lock_clr   <= lock_clr_n;
      sw_out     <= sw_out_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      fail_code  <= fail_code_n;
      fail_idx   <= fail_idx_n;
      unlock_len <= unlock_len_n;
    end
  end

  always_comb begin
    state_n      = state;
    code_n       = code_q;
    idx_n        = idx;
    wait_cnt_n   = wait_cnt;
    lock_clr_n   = lock_clr;
    sw_out_n     = sw_out;
    busy_n       = busy;
    done_n       = 1'b0;
    pass_n       = pass;
    fail_code_n  = fail_code;
    fail_idx_n   = fail_idx;
    unlock_len_n = unlock_len;

    // Any transition into FIN pulses done and re-clears the lock.
    unique case (state)
      S_IDLE: begin
        lock_clr_n = 1'b1;
        busy_n     = 1'b0;
        if (start) begin
          code_n       = code;
          pass_n       = 1'b0;
          fail_code_n  = FC_NONE;
          fail_idx_n   = 2'b00;
          unlock_len_n = '0;
          busy_n       = 1'b1;
          lock_clr_n   = 1'b0;
          idx_n        = 2'd0;
          sw_out_n     = code[2:0];
          state_n      = S_SEND;
        end
      end
      S_SEND: begin
        if (!alarm) begin
          // Alarm reports the digit the lock consumed on the previous edge.
          fail_code_n = FC_WRONG;
          fail_idx_n  = 2'(idx - 2'd1);
          state_n     = S_FIN;
        end else if (selsw != idx) begin
          fail_code_n = FC_DESYNC;
          fail_idx_n  = idx;
          state_n     = S_FIN;
        end else if (idx != 2'd3) begin
          idx_n    = 2'(idx + 2'd1);
          sw_out_n = digit(code_q, 2'(idx + 2'd1));
        end else begin
          sw_out_n   = IDLE_SW;
          wait_cnt_n = '0;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!alarm) begin
          fail_code_n = FC_WRONG;
          fail_idx_n  = 2'd3;
          state_n     = S_FIN;
        end else if (!locked && entimer) begin
          unlock_len_n = LEN_W'(1);
          state_n      = S_MEAS;
        end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
          fail_code_n = FC_TIMEOUT;
          fail_idx_n  = 2'd3;
          state_n     = S_FIN;
        end else begin
          wait_cnt_n = WAIT_W'(wait_cnt + 1'b1);
        end
      end
      S_MEAS: begin
        if (locked || unlock_len == LEN_MAX) begin
          pass_n  = 1'b1;
          state_n = S_FIN;
        end else begin
          unlock_len_n = LEN_W'(unlock_len + 1'b1);
        end
      end
      S_FIN: begin
        busy_n   = 1'b0;
        lock_clr_n = 1'b1;
        sw_out_n = IDLE_SW;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state != S_FIN && state != S_IDLE && state_n == S_FIN) begin
      done_n     = 1'b1;
      lock_clr_n = 1'b1;
      sw_out_n   = IDLE_SW;
    end
  end

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender with a small behavioural lock model.
module tb_lock_code_sender;
  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [11:0] code;
  logic [1:0]  selsw;
  logic        locked, alarm, entimer;
  logic        lock_clr;
  logic [2:0]  sw_out;
  logic        busy, done, pass;
  logic [1:0]  fail_code, fail_idx;
  logic [7:0]  unlock_len;

  int total = 0;
  int bad = 0;

  // lock model
  logic [11:0] lock_code = {3'd3, 3'd2, 3'd1, 3'd0};
  logic [1:0]  l_sel;
  logic        l_alarm, l_locked, l_ent, l_fin;
  int          l_tmr;
  int          unlock_cycles = 10;
  bit          dead = 1'b0;
  bit          force_sel = 1'b0;

  assign selsw   = force_sel ? 2'd2 : l_sel;
  assign alarm   = l_alarm;
  assign locked  = l_locked;
  assign entimer = l_ent;

  always #5 clk = ~clk;

  lock_code_sender dut (
    .clk(clk), .clear(clear), .start(start), .code(code), .selsw(selsw),
    .locked(locked), .alarm(alarm), .entimer(entimer), .lock_clr(lock_clr),
    .sw_out(sw_out), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_idx(fail_idx), .unlock_len(unlock_len)
  );

  always @(posedge clk) begin
    if (lock_clr) begin
      l_sel <= 2'd0; l_alarm <= 1'b1; l_locked <= 1'b1; l_ent <= 1'b0;
      l_tmr <= 0; l_fin <= 1'b0;
    end else if (!l_fin && l_alarm) begin
      if (l_locked) begin
        if (sw_out == lock_code[int'(l_sel)*3 +: 3]) begin
          if (l_sel == 2'd3) begin
            if (dead) l_fin <= 1'b1;
            else begin l_locked <= 1'b0; l_ent <= 1'b1; l_tmr <= 1; end
          end else l_sel <= l_sel + 2'd1;
        end else l_alarm <= 1'b0;
      end else if (l_tmr == unlock_cycles) begin
        l_locked <= 1'b1; l_ent <= 1'b0; l_fin <= 1'b1;
      end else l_tmr <= l_tmr + 1;
    end
  end

  task automatic start_pulse(input logic [11:0] c);
    @(negedge clk);
    code = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
    end
  endtask

  task automatic idle_gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (lock_clr !== 1'b1) begin bad++; $display("FAIL reset lock_clr got=%b exp=1", lock_clr); end
    total++; if (sw_out !== 3'b111) begin bad++; $display("FAIL reset sw_out got=%0d exp=7", sw_out); end
    total++; if ({busy, done, pass, fail_code, fail_idx, unlock_len} !== 15'd0) begin
      bad++; $display("FAIL reset outputs got busy=%b done=%b pass=%b fc=%b fi=%0d len=%0d exp all 0",
                      busy, done, pass, fail_code, fail_idx, unlock_len);
    end
    @(negedge clk); clear = 1'b0;
    idle_gap();
  endtask

  task automatic test_correct();
    int cyc;
    logic [2:0] seen [4];
    start_pulse({3'd3, 3'd2, 3'd1, 3'd0});
    seen[0] = sw_out;
    for (int i = 1; i < 4; i++) begin @(posedge clk); #1; seen[i] = sw_out; end
    for (int i = 0; i < 4; i++) begin
      total++; if (seen[i] !== 3'(i)) begin bad++; $display("FAIL correct sw_out[%0d] got=%0d exp=%0d", i, seen[i], i); end
    end
    wait_done(40, cyc);
    total++; if (cyc !== 12) begin bad++; $display("FAIL correct done_latency got=%0d exp=12", cyc); end
    total++; if (pass !== 1'b1 || fail_code !== 2'b00) begin bad++; $display("FAIL correct result got pass=%b fc=%b exp pass=1 fc=00", pass, fail_code); end
    total++; if (unlock_len !== 8'd10) begin bad++; $display("FAIL correct unlock_len got=%0d exp=10", unlock_len); end
    @(posedge clk); #1;
    total++; if (lock_clr !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL correct after_fin got lock_clr=%b busy=%b done=%b exp 1 0 0", lock_clr, busy, done);
    end
    idle_gap();
  endtask

  task automatic test_wrong_digit();
    int cyc;
    start_pulse({3'd3, 3'd5, 3'd1, 3'd0});
    wait_done(40, cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL wrong done_latency got=%0d exp=4", cyc); end
    total++; if (fail_code !== 2'b01 || fail_idx !== 2'd2) begin bad++; $display("FAIL wrong code got fc=%b fi=%0d exp fc=01 fi=2", fail_code, fail_idx); end
    total++; if (pass !== 1'b0 || unlock_len !== 8'd0) begin bad++; $display("FAIL wrong nomeas got pass=%b len=%0d exp 0 0", pass, unlock_len); end
    idle_gap();
  endtask

  task automatic test_desync();
    start_pulse({3'd3, 3'd2, 3'd1, 3'd0});
    @(posedge clk); #1; force_sel = 1'b1;
    @(posedge clk); #1; force_sel = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL desync done got=%b exp=1", done); end
    total++; if (fail_code !== 2'b10 || fail_idx !== 2'd1 || pass !== 1'b0) begin
      bad++; $display("FAIL desync code got fc=%b fi=%0d pass=%b exp fc=10 fi=1 pass=0", fail_code, fail_idx, pass);
    end
    idle_gap();
  endtask

  task automatic test_timeout();
    int cyc;
    dead = 1'b1;
    start_pulse({3'd3, 3'd2, 3'd1, 3'd0});
    wait_done(60, cyc);
    total++; if (cyc !== 20) begin bad++; $display("FAIL timeout latency got=%0d exp=20", cyc); end
    total++; if (fail_code !== 2'b11 || fail_idx !== 2'd3 || pass !== 1'b0) begin
      bad++; $display("FAIL timeout code got fc=%b fi=%0d pass=%b exp fc=11 fi=3 pass=0", fail_code, fail_idx, pass);
    end
    dead = 1'b0;
    idle_gap();
  endtask

  task automatic test_clear_abort();
    int cyc;
    bit saw_done = 1'b0;
    start_pulse({3'd3, 3'd2, 3'd1, 3'd0});
    @(posedge clk); @(posedge clk); #2;
    total++; if (sw_out !== 3'd2) begin bad++; $display("FAIL abort pre sw_out got=%0d exp=2", sw_out); end
    clear = 1'b1; #1;
    total++; if (lock_clr !== 1'b1 || busy !== 1'b0 || sw_out !== 3'b111) begin
      bad++; $display("FAIL abort async got lock_clr=%b busy=%b sw=%0d exp 1 0 7", lock_clr, busy, sw_out);
    end
    @(negedge clk); clear = 1'b0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort done got=1 exp=0"); end
    start_pulse({3'd3, 3'd2, 3'd1, 3'd0});
    wait_done(40, cyc);
    total++; if (cyc !== 15 || pass !== 1'b1 || unlock_len !== 8'd10) begin
      bad++; $display("FAIL abort rerun got cyc=%0d pass=%b len=%0d exp 15 1 10", cyc, pass, unlock_len);
    end
    idle_gap();
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    code = {3'd3, 3'd2, 3'd1, 3'd0}; start = 1'b1;
    @(posedge clk); #1;
    wait_done(40, cyc);
    total++; if (cyc !== 15 || pass !== 1'b1) begin bad++; $display("FAIL b2b first got cyc=%0d pass=%b exp 15 1", cyc, pass); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || pass !== 1'b1) begin bad++; $display("FAIL b2b idle got busy=%b pass=%b exp 0 1", busy, pass); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b1 || pass !== 1'b0 || unlock_len !== 8'd0 || sw_out !== 3'd0) begin
      bad++; $display("FAIL b2b restart got busy=%b pass=%b len=%0d sw=%0d exp 1 0 0 0", busy, pass, unlock_len, sw_out);
    end
    start = 1'b0;
    wait_done(40, cyc);
    total++; if (cyc !== 15 || pass !== 1'b1 || unlock_len !== 8'd10) begin
      bad++; $display("FAIL b2b second got cyc=%0d pass=%b len=%0d exp 15 1 10", cyc, pass, unlock_len);
    end
    idle_gap();
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; code = '0;
    test_reset();
    test_correct();
    test_wrong_digit();
    test_desync();
    test_timeout();
    test_clear_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
